// File: rtl/stage_id.sv
// stage_id: instruction decode, 16x32 register file with write-back port,
// load-use hazard detection and the ID/EX pipeline register.
module stage_id #(
  parameter int N  = 32,
  parameter int R  = 16,
  localparam int RW = $clog2(R)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  instruction_id_i,
  input  logic          flush_i,
  input  logic          wb_we_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [N-1:0]  wb_data_i,
  output logic          stall_o,
  output logic [1:0]    branchselect_id_o,
  output logic [N-1:0]  rs1_data_ex_o,
  output logic [N-1:0]  rs2_data_ex_o,
  output logic [N-1:0]  extend_ex_o,
  output logic [RW-1:0] rd_ex_o,
  output logic [3:0]    alu_op_ex_o,
  output logic          alu_src_ex_o,
  output logic          reg_we_ex_o,
  output logic          mem_we_ex_o,
  output logic          mem_to_reg_ex_o,
  output logic [1:0]    branchselect_ex_o
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_B    = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;

  typedef struct packed {
    logic [N-1:0]  rs1_data;
    logic [N-1:0]  rs2_data;
    logic [N-1:0]  extend;
    logic [RW-1:0] rd;
    logic [3:0]    alu_op;
    logic          alu_src;
    logic          reg_we;
    logic          mem_we;
    logic          mem_to_reg;
    logic [1:0]    bsel;
  } idex_t;

  // Instruction fields; bits [27:26] carry nothing.
  logic [3:0]    opcode;
  logic [RW-1:0] rd_f, rs1_f, rs2_f;
  logic [13:0]   imm_f;
  logic          unused_bits;

  assign opcode      = instruction_id_i[31:28];
  assign rd_f        = instruction_id_i[25:22];
  assign rs1_f       = instruction_id_i[21:18];
  assign rs2_f       = instruction_id_i[17:14];
  assign imm_f       = instruction_id_i[13:0];
  assign unused_bits = ^instruction_id_i[27:26];

  logic [R-1:0][N-1:0] rf_q;
  idex_t               ex_q, ex_d, dec;
  logic                use_rs1, use_rs2;
  logic [N-1:0]        rs1_rd, rs2_rd;

  // Register file write port; R0 is never written so it stays zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                              rf_q          <= '0;
    else if (wb_we_i && wb_rd_i != '0)     rf_q[wb_rd_i] <= wb_data_i;
  end

  // Read ports with write-first bypass so a same-cycle write-back is seen.
  always_comb begin
    rs1_rd = rf_q[rs1_f];
    rs2_rd = rf_q[rs2_f];
    if (wb_we_i && wb_rd_i == rs1_f) rs1_rd = wb_data_i;
    if (wb_we_i && wb_rd_i == rs2_f) rs2_rd = wb_data_i;
    if (rs1_f == '0) rs1_rd = '0;
    if (rs2_f == '0) rs2_rd = '0;
  end

  // Opcode decode; unknown opcodes decode exactly like NOP.
  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.rs1_data = rs1_rd;
    dec.rs2_data = rs2_rd;
    dec.extend   = {{(N-14){imm_f[13]}}, imm_f};
    dec.rd       = rd_f;
    case (opcode)
      OP_ADD, OP_SUB: begin
        dec.alu_op = opcode; dec.reg_we = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_op = opcode; dec.reg_we = 1'b1; dec.alu_src = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LW: begin
        dec.alu_op = opcode; dec.reg_we = 1'b1; dec.mem_to_reg = 1'b1;
        dec.alu_src = 1'b1; use_rs1 = 1'b1;
      end
      OP_SW: begin
        dec.alu_op = opcode; dec.mem_we = 1'b1; dec.alu_src = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_B: begin
        dec.alu_op = opcode; dec.bsel = 2'b01;
      end
      OP_BEQ: begin
        dec.alu_op = opcode; dec.bsel = 2'b10;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op = opcode; dec.bsel = 2'b11;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: dec.alu_op = OP_NOP;
    endcase
  end

  // Load-use hazard: a load in EX whose destination feeds this instruction.
  always_comb begin
    stall_o = ex_q.mem_to_reg && (ex_q.rd != '0) &&
              ((use_rs1 && rs1_f == ex_q.rd) || (use_rs2 && rs2_f == ex_q.rd));
    branchselect_id_o = stall_o ? 2'b00 : dec.bsel;
  end

  // Next ID/EX contents: flush or stall both insert an all-zero bubble.
  always_comb begin
    ex_d = dec;
    if (flush_i || stall_o) ex_d = '0;
  end

  // ID/EX pipeline register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign rs1_data_ex_o     = ex_q.rs1_data;
  assign rs2_data_ex_o     = ex_q.rs2_data;
  assign extend_ex_o       = ex_q.extend;
  assign rd_ex_o           = ex_q.rd;
  assign alu_op_ex_o       = ex_q.alu_op;
  assign alu_src_ex_o      = ex_q.alu_src;
  assign reg_we_ex_o       = ex_q.reg_we;
  assign mem_we_ex_o       = ex_q.mem_we;
  assign mem_to_reg_ex_o   = ex_q.mem_to_reg;
  assign branchselect_ex_o = ex_q.bsel;

endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id: scoreboard bench for stage_id; expected ID/EX contents are
// queued as each instruction is driven and compared one edge later.
module tb_stage_id;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] instr;
  logic        flush, wb_we;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_o;
  logic [1:0]  bs_id, bs_ex;
  logic [31:0] a_ex, b_ex, ext_ex;
  logic [3:0]  rd_ex, op_ex;
  logic        src_ex, rwe_ex, mwe_ex, m2r_ex;

  typedef struct packed {
    logic [31:0] a, b, ext;
    logic [3:0]  rd, op;
    logic        src, rwe, mwe, m2r;
    logic [1:0]  bs;
  } ex_t;

  ex_t         q[$];
  ex_t         mex;
  logic [31:0] mrf [16];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  stage_id dut (
    .CLK(CLK), .RST(RST), .instruction_id_i(instr), .flush_i(flush),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .stall_o(stall_o), .branchselect_id_o(bs_id),
    .rs1_data_ex_o(a_ex), .rs2_data_ex_o(b_ex), .extend_ex_o(ext_ex),
    .rd_ex_o(rd_ex), .alu_op_ex_o(op_ex), .alu_src_ex_o(src_ex),
    .reg_we_ex_o(rwe_ex), .mem_we_ex_o(mwe_ex), .mem_to_reg_ex_o(m2r_ex),
    .branchselect_ex_o(bs_ex)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [13:0] imm);
    return {op, 2'b00, rd, rs1, rs2, imm};
  endfunction

  task automatic cmp_ex(input string tag, input ex_t e);
    chk({tag, ".a"},   a_ex,   e.a);
    chk({tag, ".b"},   b_ex,   e.b);
    chk({tag, ".ext"}, ext_ex, e.ext);
    chk({tag, ".rd"},  {28'd0, rd_ex}, {28'd0, e.rd});
    chk({tag, ".op"},  {28'd0, op_ex}, {28'd0, e.op});
    chk({tag, ".src"}, {31'd0, src_ex}, {31'd0, e.src});
    chk({tag, ".rwe"}, {31'd0, rwe_ex}, {31'd0, e.rwe});
    chk({tag, ".mwe"}, {31'd0, mwe_ex}, {31'd0, e.mwe});
    chk({tag, ".m2r"}, {31'd0, m2r_ex}, {31'd0, e.m2r});
    chk({tag, ".bs"},  {30'd0, bs_ex},  {30'd0, e.bs});
  endtask

  // One ID cycle: drive, check combinational outputs, predict ID/EX, clock, compare.
  task automatic step(input string tag, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [3:0] wrd, input logic [31:0] wd);
    ex_t        e;
    logic [3:0] op, rs1, rs2;
    logic       u1, u2, stl;
    instr = ins; flush = fl; wb_we = we; wb_rd = wrd; wb_data = wd;
    op = ins[31:28]; rs1 = ins[21:18]; rs2 = ins[17:14];
    e = '0;
    u1 = 1'b0; u2 = 1'b0;
    case (op)
      4'h1, 4'h2: begin e.rwe = 1; u1 = 1; u2 = 1; end
      4'h3:       begin e.rwe = 1; e.src = 1; u1 = 1; end
      4'h4:       begin e.rwe = 1; e.m2r = 1; e.src = 1; u1 = 1; end
      4'h5:       begin e.mwe = 1; e.src = 1; u1 = 1; u2 = 1; end
      4'h6:       e.bs = 2'b01;
      4'h7:       begin e.bs = 2'b10; u1 = 1; u2 = 1; end
      4'h8:       begin e.bs = 2'b11; u1 = 1; u2 = 1; end
      default:    ;
    endcase
    e.op  = (op <= 4'h8) ? op : 4'h0;
    e.rd  = ins[25:22];
    e.ext = {{18{ins[13]}}, ins[13:0]};
    e.a   = (rs1 == 0) ? 32'd0 : (we && wrd == rs1) ? wd : mrf[rs1];
    e.b   = (rs2 == 0) ? 32'd0 : (we && wrd == rs2) ? wd : mrf[rs2];
    stl   = mex.m2r && mex.rd != 0 && ((u1 && rs1 == mex.rd) || (u2 && rs2 == mex.rd));
    #1;
    chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, stl});
    chk({tag, ".bs_id"}, {30'd0, bs_id}, stl ? 32'd0 : {30'd0, e.bs});
    if (fl || stl) e = '0;
    q.push_back(e);
    if (we && wrd != 0) mrf[wrd] = wd;
    mex = e;
    @(posedge CLK);
    #1;
    cmp_ex(tag, q.pop_front());
  endtask

  initial begin
    RST = 1'b0; instr = '0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    mex = '0;
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    #12;
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    cmp_ex("rst", '0);
    @(negedge CLK); RST = 1'b1;

    // bypass: write R3 while ADD reads it
    step("byp", mk(4'h1, 4'd4, 4'd3, 4'd0, 14'd0), 0, 1, 4'd3, 32'h0000_00AB);
    step("addi_neg", mk(4'h3, 4'd2, 4'd0, 4'd0, 14'h3FF4), 0, 0, 0, 0);
    step("addi_pos", mk(4'h3, 4'd2, 4'd0, 4'd0, 14'd12), 0, 0, 0, 0);
    step("wr5", 32'd0, 0, 1, 4'd5, 32'h0000_0100);
    step("wr6", 32'd0, 0, 1, 4'd6, 32'h0000_0055);
    // load-use: one stall, then issue
    step("lw", mk(4'h4, 4'd5, 4'd0, 4'd0, 14'd4), 0, 0, 0, 0);
    step("lu_stall", mk(4'h1, 4'd7, 4'd5, 4'd6, 14'd0), 0, 0, 0, 0);
    step("lu_issue", mk(4'h1, 4'd7, 4'd5, 4'd6, 14'd0), 0, 0, 0, 0);
    // load followed by independent store: no stall
    step("lw2", mk(4'h4, 4'd5, 4'd0, 4'd0, 14'd4), 0, 0, 0, 0);
    step("sw", mk(4'h5, 4'd0, 4'd0, 4'd6, 14'd8), 0, 0, 0, 0);
    // branch then flush
    step("beq", mk(4'h7, 4'd0, 4'd5, 4'd6, 14'h3FFC), 0, 0, 0, 0);
    step("flush", mk(4'h1, 4'd8, 4'd5, 4'd6, 14'd0), 1, 0, 0, 0);
    // flush with a stall pending
    step("lw3", mk(4'h4, 4'd5, 4'd0, 4'd0, 14'd0), 0, 0, 0, 0);
    step("fl_stall", mk(4'h1, 4'd9, 4'd5, 4'd0, 14'd0), 1, 0, 0, 0);
    step("fl_after", mk(4'h1, 4'd9, 4'd5, 4'd0, 14'd0), 0, 0, 0, 0);
    // R0 write ignored; unknown opcode decodes as NOP
    step("wr0", 32'd0, 0, 1, 4'd0, 32'hFFFF_FFFF);
    step("rd0", mk(4'h1, 4'd1, 4'd0, 4'd0, 14'd0), 0, 0, 0, 0);
    step("opC", mk(4'hC, 4'd3, 4'd5, 4'd6, 14'h2001), 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step("rnd", mk(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom_range(0, 7)),
                     4'($urandom_range(0, 7)), 14'($urandom)),
           ($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom_range(0, 7)), $urandom);
    end

    // asynchronous reset mid-run with ADD held in ID/EX
    step("pre_rst", mk(4'h1, 4'd10, 4'd5, 4'd6, 14'd3), 0, 1, 4'd7, 32'h1234_5678);
    #2; RST = 1'b0;
    #1;
    cmp_ex("async_rst", '0);
    mex = '0;
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    @(negedge CLK); RST = 1'b1;
    for (int i = 1; i < 16; i++)
      step("post_rst", mk(4'h1, 4'd1, 4'(i), 4'(i), 14'd0), 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_id.md
Name: stage_id

Overview:
- Instruction-decode stage sitting between Pipe_IF_ID and the EX stage.
- Decodes the 32-bit instruction held in IF/ID and reads a 16x32 register file, including the write-back port.
- Detects load-use hazards, asserting a stall to PC/IF and inserting a bubble toward EX.
- Owns the ID/EX pipeline register; honours flushes from PC_controller.

Parameters:
- N, 32, data/instruction width
- R, 16, number of architectural registers (index width = clog2(R) = 4)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- instruction_id_i  in  N  instruction from Pipe_IF_ID
- flush_i  in  1  clear_pipes_o from PC_controller; turns ID/EX into a bubble
- wb_we_i  in  1  write-back enable
- wb_rd_i  in  4  write-back destination
- wb_data_i  in  N  write-back data
- stall_o  out  1  combinational; holds PC and IF/ID when 1
- branchselect_id_o  out  2  combinational; to PC_controller
- rs1_data_ex_o  out  N  registered operand A
- rs2_data_ex_o  out  N  registered operand B / store data
- extend_ex_o  out  N  registered sign-extended immediate (byte offset for PC_label)
- rd_ex_o  out  4  registered destination
- alu_op_ex_o  out  4  registered ALU op (= opcode)
- alu_src_ex_o  out  1  registered; 1 selects immediate
- reg_we_ex_o  out  1  registered
- mem_we_ex_o  out  1  registered
- mem_to_reg_ex_o  out  1  registered
- branchselect_ex_o  out  2  registered copy for PC_controller

Behaviour:
- Instruction fields: [31:28] opcode; [25:22] rd; [21:18] rs1; [17:14] rs2; [13:0] imm. Bits [27:26] ignored.
- Extend = imm[13:0] sign-extended to N bits.
- Opcodes (reg_we / mem_we / mem_to_reg / alu_src / branchselect):
  - 0x0 NOP: 0/0/0/0/00
  - 0x1 ADD: 1/0/0/0/00
  - 0x2 SUB: 1/0/0/0/00
  - 0x3 ADDI: 1/0/0/1/00
  - 0x4 LW: 1/0/1/1/00
  - 0x5 SW: 0/1/0/1/00
  - 0x6 B: 0/0/0/0/01
  - 0x7 BEQ: 0/0/0/0/10
  - 0x8 BNE: 0/0/0/0/11
  - 0x9-0xF: decode as NOP.
- Operand use: rs1 is used by ADD, SUB, ADDI, LW, SW, BEQ, BNE. rs2 is used by ADD, SUB, SW, BEQ, BNE.
- Register file:
  - Written on the rising edge when wb_we_i=1 and wb_rd_i≠0.
  - R0 always reads 0; writes to R0 are ignored.
  - Write-first bypass: a same-cycle read of wb_rd_i (≠0) with wb_we_i=1 returns wb_data_i.
- Hazard detection: stall_o=1 when mem_to_reg_ex_o=1, rd_ex_o≠0, and rd_ex_o equals a used rs1/rs2 of the current instruction. At most one stall cycle per load.
- ID/EX update each rising edge, in priority order:
  - flush_i=1: load a bubble (all control=0, branchselect=00, data/rd=0).
  - Otherwise stall_o=1: load a bubble.
  - Otherwise: load the decoded values.
- Timing: branchselect_id_o is forced to 00 while stall_o=1. Latency ID→EX is 1 cycle.
- Reset (RST=0, asynchronous): all registered outputs = 0, all registers = 0, so stall_o=0 and branchselect_id_o=decode of input. Reset asserted mid-operation discards the in-flight ID/EX contents immediately. On release, the first rising edge loads normally.
- Simultaneous flush_i and stall_o: flush wins; the result is the same bubble. Stall is released next cycle because mem_to_reg_ex_o=0.

Test Plan:
- Reset: RST=0 mid-run with ID/EX holding ADD → all *_ex_o=0 before the next edge; after release, R1..R15 read 0.
- Write/read bypass: wb writes R3=0x0000_00AB while ID decodes ADD rd=4 rs1=3 rs2=0 → next edge rs1_data_ex_o=0xAB, rs2_data_ex_o=0, reg_we_ex_o=1, alu_op_ex_o=1.
- Immediate: ADDI rd=2 rs1=0 imm=0x3FF4 → extend_ex_o=0xFFFF_FFF4 (-12), alu_src_ex_o=1; imm=12 → 0x0000_000C.
- Load-use: LW rd=5, then ADD rs1=5 → stall_o=1 for exactly one cycle, ID/EX bubble, then ADD issues. LW rd=5 followed by SW with rs1=0, rs2=6 → no stall.
- Branch/flush: BEQ in ID → branchselect_id_o=10, branchselect_ex_o=10 one cycle later. flush_i=1 on that cycle → following ID/EX all 0. flush_i with a stall pending → bubble, stall cleared next cycle.
- R0 write: wb_we_i=1, wb_rd_i=0, data 0xFFFF_FFFF → subsequent read of R0 = 0; opcode 0xC → all control 0.
